// File: rtl/hansen_mem_arbiter.sv
// N-master arbiter in front of a word-addressed on-chip RAM.
// Fixed priority with a starvation guard, or round-robin.
module hansen_mem_arbiter #(
  parameter int NUM_MASTERS  = 3,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH_WORDS  = 16384,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 8,
  parameter int ID_W         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic                          rd_valid,
  output logic [ID_W-1:0]               rd_id,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          err_valid,
  output logic [ID_W-1:0]               err_id
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int WIDX_W  = ADDR_W - BYTE_SH;
  localparam int RAM_AW  = $clog2(DEPTH_WORDS);
  localparam int PTR_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [PTR_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       starve_cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] gnt_c;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic                   accept;
  int                     j;

  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    if (ARB_MODE == 1) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        j = (int'(rr_ptr) + k) % NUM_MASTERS;
        if (!gnt_any && m_req[j]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(j);
        end
      end
    end else begin
      // A starved master overrides plain priority; lowest starved index first.
      if (STARVE_LIMIT > 0) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (!gnt_any && m_req[i] && starve_cnt[i] == CNT_W'(STARVE_LIMIT)) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(i);
          end
        end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!gnt_any && m_req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(i);
        end
      end
    end
    if (gnt_any && !reset) gnt_c[gnt_idx] = 1'b1;
  end

  assign m_gnt  = gnt_c;
  assign accept = gnt_any && !reset;

  logic [WIDX_W-1:0] word;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  assign word      = m_addr[int'(gnt_idx)*ADDR_W + BYTE_SH +: WIDX_W];
  assign ram_idx   = word[RAM_AW-1:0];
  assign sel_we    = m_we[gnt_idx];
  assign sel_wdata = m_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

  // Any set bit above the RAM index is out of range; no aliasing.
  if (WIDX_W > RAM_AW) begin : g_hi
    assign in_range = ~|word[WIDX_W-1:RAM_AW];
  end else begin : g_nohi
    assign in_range = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) starve_cnt[i] <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (m_req[i] && !gnt_c[i]) begin
          if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (accept && sel_we && in_range) mem[ram_idx] <= sel_wdata;
  end

  logic rd_valid_q;
  logic err_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      err_valid_q <= 1'b0;
      rd_id       <= '0;
      rd_data     <= '0;
      err_id      <= '0;
    end else begin
      rd_valid_q  <= accept && !sel_we;
      err_valid_q <= accept && !in_range;
      if (accept && !sel_we) begin
        rd_id   <= ID_W'(gnt_idx);
        rd_data <= in_range ? mem[ram_idx] : '0;
      end
      if (accept && !in_range) err_id <= ID_W'(gnt_idx);
    end
  end

  // Pulses already in flight are suppressed while reset is held.
  assign rd_valid  = rd_valid_q && !reset;
  assign err_valid = err_valid_q && !reset;

endmodule
